// File: rtl/pmem_loader_ctrl.sv
// Program-memory loader: streams prog_len instruction words into program memory while holding
// the core in reset, then releases the core. Writes are registered one cycle after acceptance.
module pmem_loader_ctrl #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned INST_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] prog_len,
    input  logic              s_valid,
    input  logic [INST_W-1:0] s_data,
    output logic              s_ready,
    output logic              pmem_le,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [INST_W-1:0] pmem_inst,
    output logic              core_rst,
    output logic              load_done,
    output logic              busy,
    output logic              err,
    output logic [ADDR_W-1:0] word_count,
    output logic [INST_W-1:0] chk
);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StFlush,
        StRun
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   len_q, len_d;
    // Write index; equals the number of words accepted so it also drives word_count.
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [INST_W-1:0]   chk_q, chk_d;
    logic                le_q, le_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [INST_W-1:0]   inst_q, inst_d;
    logic                err_q, err_d;
    logic                start_ok;
    logic                start_bad;

    assign start_ok  = start && !abort && (prog_len != '0);
    assign start_bad = start && !abort && (prog_len == '0);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        chk_d   = chk_q;
        le_d    = 1'b0;
        addr_d  = addr_q;
        inst_d  = inst_q;
        err_d   = 1'b0;

        unique case (state_q)
            StIdle, StRun: begin
                if (start_ok) begin
                    state_d = StLoad;
                    len_d   = prog_len;
                    idx_d   = '0;
                    chk_d   = '0;
                end else if (start_bad) begin
                    err_d = 1'b1;
                end
            end
            StLoad: begin
                // Abort wins over a word presented on the same edge: that word is dropped.
                if (abort) begin
                    state_d = StIdle;
                end else if (s_valid) begin
                    le_d   = 1'b1;
                    addr_d = idx_q;
                    inst_d = s_data;
                    idx_d  = idx_q + ADDR_W'(1);
                    chk_d  = chk_q ^ s_data;
                    if (idx_q == len_q - ADDR_W'(1)) begin
                        state_d = StFlush;
                    end
                end
            end
            StFlush: begin
                state_d = StRun;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            len_q   <= '0;
            idx_q   <= '0;
            chk_q   <= '0;
            le_q    <= 1'b0;
            addr_q  <= '0;
            inst_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            chk_q   <= chk_d;
            le_q    <= le_d;
            addr_q  <= addr_d;
            inst_q  <= inst_d;
            err_q   <= err_d;
        end
    end

    assign s_ready    = (state_q == StLoad);
    assign busy       = (state_q == StLoad) || (state_q == StFlush);
    assign load_done  = (state_q == StRun);
    assign core_rst   = (state_q != StRun);
    assign pmem_le    = le_q;
    assign pmem_addr  = addr_q;
    assign pmem_inst  = inst_q;
    assign err        = err_q;
    assign word_count = idx_q;
    assign chk        = chk_q;

endmodule

// File: doc/pmem_loader_ctrl.md
PMEM_LOADER_CTRL -- requirements
Module: pmem_loader_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: program-memory address width.
REQ-002 SHALL have parameter INST_W, default 12: instruction width.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1: single-cycle request to begin a program load.
REQ-006 SHALL have port abort  input  1: cancels an in-progress load.
REQ-007 SHALL have port prog_len  input  ADDR_W: number of instructions to load, sampled when start is accepted.
REQ-008 SHALL have port s_valid  input  1: instruction stream word valid.
REQ-009 SHALL have port s_data  input  INST_W: instruction stream word.
REQ-010 SHALL have port s_ready  output  1: controller accepts s_data this cycle.
REQ-011 SHALL have port pmem_le  output  1: program-memory load enable, one cycle per word.
REQ-012 SHALL have port pmem_addr  output  ADDR_W: program-memory load address.
REQ-013 SHALL have port pmem_inst  output  INST_W: instruction written to program memory.
REQ-014 SHALL have port core_rst  output  1: active-high hold-reset to the processor core.
REQ-015 SHALL have port load_done  output  1: level, program image complete and core released.
REQ-016 SHALL have port busy  output  1: high while in LOAD or FLUSH.
REQ-017 SHALL have port err  output  1: one-cycle pulse on rejected start.
REQ-018 SHALL have port word_count  output  ADDR_W: words accepted in the current/last load.
REQ-019 SHALL have port chk  output  INST_W: XOR of all words accepted in the current/last load.

Function
REQ-020 SHALL implement FSM states IDLE, LOAD, FLUSH, RUN.
REQ-021 IDLE: start=1 and prog_len!=0 and abort=0 SHALL go to LOAD; the edge latches len, clears word_count, chk, index.
REQ-022 IDLE: start=1 with prog_len==0 SHALL stay IDLE and pulse err for exactly one cycle the following cycle.
REQ-023 s_ready SHALL equal (state==LOAD), combinationally; a transfer occurs on an edge where s_valid&&s_ready.
REQ-024 A transfer at edge N SHALL drive pmem_le=1, pmem_addr=index, pmem_inst=s_data in the cycle after edge N only (registered, 1-cycle latency).
REQ-025 Each transfer SHALL increment index and word_count by 1 and XOR s_data into chk.
REQ-026 Transfer with index==len-1 SHALL move LOAD to FLUSH; no further words accepted.
REQ-027 FLUSH SHALL last exactly one cycle (final pmem_le issued) then go to RUN.
REQ-028 RUN: load_done=1, core_rst=0, busy=0; all other states: load_done=0, core_rst=1.
REQ-029 RUN: start=1 with prog_len!=0 SHALL go to LOAD (reload); core_rst SHALL rise the following cycle.
REQ-030 LOAD/FLUSH: start SHALL be ignored.
REQ-031 LOAD: abort=1 SHALL go to IDLE; a word transferred on the same edge SHALL NOT be written; a write already registered SHALL complete.
REQ-032 abort SHALL have priority over start in every state; abort in IDLE/RUN/FLUSH SHALL have no effect.
REQ-033 s_valid low in LOAD SHALL stall indefinitely with no pmem_le and no state change.
REQ-034 pmem_le SHALL never be high for more than len cycles per load; pmem_addr SHALL never exceed len-1.
REQ-035 word_count and chk SHALL hold their final values in IDLE/RUN until the next accepted start.

Reset
REQ-036 rst=0 SHALL asynchronously force IDLE, s_ready=0, pmem_le=0, pmem_addr=0, pmem_inst=0, core_rst=1, load_done=0, busy=0, err=0, word_count=0, chk=0.
REQ-037 Reset mid-LOAD SHALL abandon the load immediately with no further pmem_le.
REQ-038 After rst rises, the first start SHALL be honoured no earlier than the first rising clk edge.

Verification
REQ-039 prog_len=3, words 0x101,0x202,0x404 back-to-back -> pmem_le 3 consecutive cycles, addr 0,1,2; load_done high 2 cycles after last transfer; chk=0x707, word_count=3.
REQ-040 prog_len=2, s_valid toggled 1,0,0,1 -> exactly 2 writes at addr 0,1; no pmem_le during gaps.
REQ-041 start with prog_len=0 -> err one-cycle pulse, state IDLE, no pmem_le, core_rst=1.
REQ-042 prog_len=4, abort after 2nd transfer together with 3rd word -> writes addr 0,1 only; IDLE, load_done=0, word_count=2.
REQ-043 In RUN, start with prog_len=1, word 0xABC -> core_rst rises next cycle, one write addr 0 data 0xABC, load_done returns, chk=0xABC.
REQ-044 rst=0 asserted mid-LOAD between clock edges -> all outputs at reset values before next edge; no further pmem_le.
